stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr.sv | 125 ++++++++++++
 tb/tb_stream_mux_rr.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   Multiplexes NCH valid/ready input streams onto one registered output
//   stream. MODE=0 picks the channel named by sel; MODE=1 round-robins over
//   the channels with in_valid set, starting the search at ptr.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      NCH*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   in_valid     per-channel valid
//   in_ready     per-channel ready, one-hot or zero
//   sel          fixed channel select (MODE=0 only)
//   out_data     registered output word
//   out_valid    registered output valid
//   out_ready    downstream ready
//   out_chan     channel index that sourced out_data
module stream_mux_rr #(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int MODE  = 1,
    localparam int SW    = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_chan
);

    logic [WIDTH-1:0] ch_data [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_split
        assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SW-1:0]    out_chan_q,  out_chan_d;
    logic [SW-1:0]    ptr_q,       ptr_d;

    logic             load;
    logic [NCH-1:0]   grant;
    logic [SW-1:0]    gidx;
    logic             in_xfer;
    logic [SW:0]      sum;
    logic [SW-1:0]    idx;
    logic             found;

    // The output register can take a new word when empty or draining.
    assign load = !out_valid_q || out_ready;

    // Grant selection depends only on sel/ptr, in_valid and load; never on data.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        if (MODE == 0) begin
            // Out-of-range select values grant nothing.
            if ({1'b0, sel} < (SW+1)'(NCH)) begin
                grant[sel] = 1'b1;
                gidx       = sel;
            end
        end else begin
            // Search upward from ptr, wrapping NCH-1 -> 0; first valid wins.
            for (int i = 0; i < NCH; i++) begin
                sum = {1'b0, ptr_q} + (SW+1)'(i);
                if (sum >= (SW+1)'(NCH)) sum = sum - (SW+1)'(NCH);
                idx = sum[SW-1:0];
                if (!found && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    gidx       = idx;
                    found      = 1'b1;
                end
            end
        end
        // Ready is held low during reset even though load reads 1 there.
        in_ready = (rst_n && load) ? grant : '0;
    end

    assign in_xfer = |(in_ready & in_valid);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (in_xfer) begin
            // Covers the simultaneous drain+fill case: no bubble.
            out_valid_d = 1'b1;
            out_data_d  = ch_data[gidx];
            out_chan_d  = gidx;
            if (MODE != 0) begin
                if (gidx == SW'(NCH-1)) ptr_d = '0;
                else                    ptr_d = gidx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: u0 fixed-select NCH=4, u1 round-robin NCH=4,
// u2 fixed-select NCH=5 (lets sel reach values beyond the last channel).
// Expected output words are queued at issue time; negedge monitors pop
// and compare on every output handshake.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int checks = 0;
    int errors = 0;

    // u0: MODE=0, NCH=4
    logic [3:0][7:0] d0;
    logic [3:0]      valid0, ready0_o;
    logic [1:0]      sel0, chan0;
    logic [7:0]      data0;
    logic            ov0, or0;

    // u1: MODE=1, NCH=4
    logic [3:0][7:0] d1;
    logic [3:0]      valid1, ready1_o;
    logic [1:0]      sel1, chan1;
    logic [7:0]      data1;
    logic            ov1, or1;

    // u2: MODE=0, NCH=5
    logic [4:0][7:0] d2;
    logic [4:0]      valid2, ready2_o;
    logic [2:0]      sel2, chan2;
    logic [7:0]      data2;
    logic            ov2, or2;

    stream_mux_rr #(.WIDTH(8), .NCH(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(valid0),
        .in_ready(ready0_o), .sel(sel0), .out_data(data0), .out_valid(ov0),
        .out_ready(or0), .out_chan(chan0));

    stream_mux_rr #(.WIDTH(8), .NCH(4), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(valid1),
        .in_ready(ready1_o), .sel(sel1), .out_data(data1), .out_valid(ov1),
        .out_ready(or1), .out_chan(chan1));

    stream_mux_rr #(.WIDTH(8), .NCH(5), .MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(valid2),
        .in_ready(ready2_o), .sel(sel2), .out_data(data2), .out_valid(ov2),
        .out_ready(or2), .out_chan(chan2));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitors: every handshake must match the next queued word.
    always @(negedge clk) begin
        if (rst_n && ov0 && or0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon0_unexpected: got d=%0h c=%0d expected no word", data0, chan0);
            end else begin
                e0 = q0.pop_front();
                check("mon0_data", 32'(data0), 32'(e0.d));
                check("mon0_chan", 32'(chan0), 32'(e0.c));
            end
        end
        if (rst_n && ov1 && or1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon1_unexpected: got d=%0h c=%0d expected no word", data1, chan1);
            end else begin
                e1 = q1.pop_front();
                check("mon1_data", 32'(data1), 32'(e1.d));
                check("mon1_chan", 32'(chan1), 32'(e1.c));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        d0     = {8'h44, 8'h33, 8'h22, 8'h11};
        d1     = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        d2     = {8'h64, 8'h63, 8'h62, 8'h61, 8'h60};
        valid0 = '0; sel0 = '0; or0 = 1'b0;
        valid1 = 4'hF; sel1 = '0; or1 = 1'b0;
        valid2 = '0; sel2 = '0; or2 = 1'b0;

        // Reset state, ready held low despite valid inputs.
        #12;
        check("rst_ov0",   32'(ov0),      0);
        check("rst_data0", 32'(data0),    0);
        check("rst_chan0", 32'(chan0),    0);
        check("rst_ov1",   32'(ov1),      0);
        check("rst_data1", 32'(data1),    0);
        check("rst_rdy1",  32'(ready1_o), 0);
        valid1 = '0;
        rst_n  = 1'b1;

        // Fixed select cycling 0..3.
        for (int s = 0; s < 4; s++) begin
            step();
            valid0 = 4'hF; or0 = 1'b1; sel0 = s[1:0];
            q0.push_back('{d: d0[s[1:0]], c: 4'(s)});
            #1;
            check("m0_ready", 32'(ready0_o), 32'(4'b0001 << s));
        end
        step();
        valid0 = '0;
        #1;
        check("m0_last_held", 32'(ov0), 1);
        step();
        check("m0_drained", 32'(ov0), 0);

        // Round-robin, all valid: grants 0,1,2,3,0 back to back.
        for (int i = 0; i < 5; i++) begin
            step();
            or1 = 1'b1; valid1 = 4'hF;
            q1.push_back('{d: d1[i[1:0]], c: 4'(i % 4)});
            #1;
            check("rr_grant", 32'(ready1_o), 32'(4'b0001 << (i % 4)));
            if (i > 0) check("rr_ov_cont", 32'(ov1), 1);
        end
        step();
        valid1 = '0;
        #1;
        check("rr_idle_rdy", 32'(ready1_o), 0);
        check("rr_ov_tail",  32'(ov1), 1);

        // Move ptr to 3 via a ch2 grant, idle a cycle, then ch0/ch2 only.
        step();
        valid1 = 4'b0100; q1.push_back('{d: 8'hC2, c: 4'd2});
        #1; check("wrap_pre", 32'(ready1_o), 32'(4'b0100));
        step();
        valid1 = '0;
        #1; check("idle_none", 32'(ready1_o), 0);
        step();
        valid1 = 4'b0101; q1.push_back('{d: 8'hA0, c: 4'd0});
        #1; check("wrap_ch0", 32'(ready1_o), 32'(4'b0001));
        step();
        q1.push_back('{d: 8'hC2, c: 4'd2});
        #1; check("wrap_ch2", 32'(ready1_o), 32'(4'b0100));

        // Backpressure: 0xA5 from ch1 held for 3 cycles.
        step();
        d1[1] = 8'hA5; valid1 = 4'b0010; q1.push_back('{d: 8'hA5, c: 4'd1});
        #1; check("bp_grant", 32'(ready1_o), 32'(4'b0010));
        step();
        or1 = 1'b0; d1[1] = 8'h5A; valid1 = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #1;
            check("bp_rdy",  32'(ready1_o), 0);
            check("bp_data", 32'(data1), 32'h A5);
            check("bp_chan", 32'(chan1), 1);
        end
        step();
        or1 = 1'b1; q1.push_back('{d: 8'hD3, c: 4'd3});
        #1; check("bp_reload", 32'(ready1_o), 32'(4'b1000));
        step();
        valid1 = '0;

        // Reset mid-stream with a held word and ptr=2.
        step();
        valid1 = 4'b0010; or1 = 1'b0;
        #1; check("mr_grant", 32'(ready1_o), 32'(4'b0010));
        step();
        valid1 = '0;
        #1; check("mr_held", 32'(ov1), 1);
        rst_n = 1'b0;
        #1;
        check("mr_ov_async",   32'(ov1),   0);
        check("mr_data_async", 32'(data1), 0);
        check("mr_chan_async", 32'(chan1), 0);
        step();
        valid1 = 4'hF; or1 = 1'b1;
        #1; check("mr_rdy_in_rst", 32'(ready1_o), 0);
        rst_n = 1'b1;
        q1.push_back('{d: 8'hA0, c: 4'd0});
        #1; check("mr_first_ch0", 32'(ready1_o), 32'(4'b0001));
        step();
        valid1 = '0;

        // Out-of-range select on the NCH=5 instance grants nothing.
        step();
        valid2 = 5'h1F; or2 = 1'b1; sel2 = 3'd5;
        #1; check("oor5_rdy", 32'(ready2_o), 0);
        step();
        sel2 = 3'd7;
        #1;
        check("oor7_rdy", 32'(ready2_o), 0);
        check("oor_ov",   32'(ov2), 0);
        step();
        check("oor_ov2", 32'(ov2), 0);
        sel2 = 3'd4;
        #1; check("sel4_rdy", 32'(ready2_o), 32'(5'b10000));
        step();
        valid2 = '0;
        #1;
        check("sel4_ov",   32'(ov2),   1);
        check("sel4_data", 32'(data2), 32'h64);
        check("sel4_chan", 32'(chan2), 4);

        step(); step(); step();
        check("q0_empty", 32'(q0.size()), 0);
        check("q1_empty", 32'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
